// File: rtl/nlp_update_gen_pkg.sv
// Shared types and helpers for the NLP update producer: packet layout, initial
// counter value and the usefulness filter applied to committed branches.
package nlp_update_gen_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  bim_state;
    logic        should_take;
  } nlp_update_pkt_t;

  localparam logic [1:0] NlpBimInit = 2'b10;

  // An update is worth sending only if it would change the NLP entry.
  function automatic logic nlp_useful(logic valid, logic hit, logic taken, logic [1:0] bim,
                                      logic [31:0] pred_target, logic [31:0] target);
    return valid && ((!hit && taken) ||
                     (hit && taken && bim != 2'b11) ||
                     (hit && !taken && bim != 2'b00) ||
                     (hit && taken && pred_target != target));
  endfunction

endpackage

// File: rtl/nlp_update_gen_if.sv
// Update channel from the commit-side producer to the NLP training port.
interface nlp_update_gen_if;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] target;
  logic [1:0]  bim_state;
  logic        should_take;

  modport master (output valid, pc, target, bim_state, should_take);
  modport slave  (input  valid, pc, target, bim_state, should_take);
endinterface

// File: rtl/nlp_upd_fifo.sv
// 2-write / 1-read FIFO of update packets with unconditional pop, in-place
// overwrite of the newest entry and per-slot drop reporting.
module nlp_upd_fifo
  import nlp_update_gen_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            wr_en_i,
  input  nlp_update_pkt_t [1:0] wr_pkt_i,
  output logic                  rd_valid_o,
  output nlp_update_pkt_t       rd_pkt_o,
  output logic [1:0]            drop_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;

  nlp_update_pkt_t mem_q [Depth];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]   count, free;
  logic            nonempty;
  logic [AW-1:0]   last_idx, waddr0, waddr1;
  logic            coal0, coal1, alloc0, alloc1, we0, we1, tail_live;

  always_comb begin
    count     = tail_q - head_q;
    nonempty  = (count != '0);
    // The head always leaves this cycle, so its slot is reusable right away.
    free      = PW'(Depth) - count + {{(PW-1){1'b0}}, nonempty};
    last_idx  = tail_q[AW-1:0] - AW'(1);
    // The newest entry is safe to overwrite only if it is not the head being popped.
    tail_live = (count > PW'(1));

    coal0  = wr_en_i[0] && tail_live && (mem_q[last_idx].pc == wr_pkt_i[0].pc);
    alloc0 = wr_en_i[0] && !coal0 && (free != '0);
    coal1  = wr_en_i[1] && tail_live && !alloc0 && (mem_q[last_idx].pc == wr_pkt_i[1].pc);
    alloc1 = wr_en_i[1] && !coal1 && (alloc0 ? (free >= PW'(2)) : (free != '0));

    drop_o[0] = wr_en_i[0] && !coal0 && !alloc0;
    drop_o[1] = wr_en_i[1] && !coal1 && !alloc1;

    we0    = coal0 || alloc0;
    we1    = coal1 || alloc1;
    waddr0 = coal0 ? last_idx : tail_q[AW-1:0];
    waddr1 = coal1 ? last_idx : (tail_q[AW-1:0] + {{(AW-1){1'b0}}, alloc0});

    head_d = head_q + {{(PW-1){1'b0}}, nonempty};
    tail_d = tail_q + {{(PW-1){1'b0}}, alloc0} + {{(PW-1){1'b0}}, alloc1};

    rd_valid_o = nonempty;
    rd_pkt_o   = mem_q[head_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (we0) mem_q[waddr0] <= wr_pkt_i[0];
      if (we1) mem_q[waddr1] <= wr_pkt_i[1];
    end
  end

endmodule

// File: rtl/nlp_update_gen.sv
// Producer end of the NLP update protocol: filters and coalesces up to two
// committed branches per cycle into a small FIFO drained one packet per cycle.
module nlp_update_gen
  import nlp_update_gen_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned CntW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cmt_valid_i,
  input  logic [1:0][31:0]      cmt_pc_i,
  input  logic [1:0][31:0]      cmt_target_i,
  input  logic [1:0]            cmt_taken_i,
  input  logic [1:0]            cmt_nlp_hit_i,
  input  logic [1:0][1:0]       cmt_bim_state_i,
  input  logic [1:0][31:0]      cmt_pred_target_i,
  nlp_update_gen_if.master      upd,
  output logic [CntW-1:0]       drop_cnt_o
);

  localparam int unsigned SumW = CntW + 1;

  logic [1:0]            useful, wr_en, fifo_drop;
  nlp_update_pkt_t [1:0] pkt;
  nlp_update_pkt_t       head_pkt;
  logic                  head_valid;
  logic [CntW-1:0]       drop_cnt_q, drop_cnt_d;
  logic [SumW-1:0]       drop_sum;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      useful[s] = nlp_useful(cmt_valid_i[s], cmt_nlp_hit_i[s], cmt_taken_i[s],
                             cmt_bim_state_i[s], cmt_pred_target_i[s], cmt_target_i[s]);
      pkt[s].pc          = cmt_pc_i[s];
      pkt[s].target      = cmt_target_i[s];
      pkt[s].bim_state   = cmt_nlp_hit_i[s] ? cmt_bim_state_i[s] : NlpBimInit;
      pkt[s].should_take = cmt_taken_i[s];
    end
    wr_en = useful;
    // The younger slot carries the final outcome for a PC seen twice this cycle.
    if (useful == 2'b11 && cmt_pc_i[0] == cmt_pc_i[1]) wr_en[0] = 1'b0;
  end

  nlp_upd_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_pkt_i   (pkt),
    .rd_valid_o (head_valid),
    .rd_pkt_o   (head_pkt),
    .drop_o     (fifo_drop)
  );

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + SumW'(fifo_drop[0]) + SumW'(fifo_drop[1]);
    drop_cnt_d = drop_sum[CntW] ? '1 : drop_sum[CntW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o      = drop_cnt_q;
  assign upd.valid       = head_valid;
  assign upd.pc          = head_pkt.pc;
  assign upd.target      = head_pkt.target;
  assign upd.bim_state   = head_pkt.bim_state;
  assign upd.should_take = head_pkt.should_take;

endmodule

// File: tb/tb_nlp_update_gen.sv
// Self-checking bench for nlp_update_gen: directed table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_nlp_update_gen;

  localparam int unsigned Depth = 8;
  localparam int unsigned CntW  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       cmt_valid;
  logic [1:0][31:0] cmt_pc, cmt_target, cmt_pred_target;
  logic [1:0]       cmt_taken, cmt_nlp_hit;
  logic [1:0][1:0]  cmt_bim_state;
  logic [CntW-1:0]  drop_cnt;

  nlp_update_gen_if upd_if ();

  nlp_update_gen #(
    .Depth (Depth),
    .CntW  (CntW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmt_valid_i       (cmt_valid),
    .cmt_pc_i          (cmt_pc),
    .cmt_target_i      (cmt_target),
    .cmt_taken_i       (cmt_taken),
    .cmt_nlp_hit_i     (cmt_nlp_hit),
    .cmt_bim_state_i   (cmt_bim_state),
    .cmt_pred_target_i (cmt_pred_target),
    .upd               (upd_if),
    .drop_cnt_o        (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  bim;
    logic        take;
  } m_pkt_t;

  typedef struct {
    logic [1:0]       v;
    logic [1:0][31:0] pc, tgt, pt;
    logic [1:0]       tk, hit;
    logic [1:0][1:0]  bim;
    logic             ev;
    logic [31:0]      epc, etgt;
    logic [1:0]       eb;
    logic             et;
  } vec_t;

  m_pkt_t          mq[$];
  logic [CntW-1:0] mdrop;
  int              n_checks = 0;
  int              n_fail = 0;
  vec_t            vecs[10];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [1:0] v,
                              logic [31:0] pc0, logic [31:0] t0, logic tk0, logic h0,
                              logic [1:0] b0, logic [31:0] p0,
                              logic [31:0] pc1, logic [31:0] t1, logic tk1, logic h1,
                              logic [1:0] b1, logic [31:0] p1,
                              logic ev, logic [31:0] epc, logic [31:0] etgt,
                              logic [1:0] eb, logic et);
    vec_t r;
    r.v = v;
    r.pc[0] = pc0; r.tgt[0] = t0; r.tk[0] = tk0; r.hit[0] = h0; r.bim[0] = b0; r.pt[0] = p0;
    r.pc[1] = pc1; r.tgt[1] = t1; r.tk[1] = tk1; r.hit[1] = h1; r.bim[1] = b1; r.pt[1] = p1;
    r.ev = ev; r.epc = epc; r.etgt = etgt; r.eb = eb; r.et = et;
    return r;
  endfunction

  task automatic drive(vec_t x);
    cmt_valid = x.v; cmt_pc = x.pc; cmt_target = x.tgt; cmt_pred_target = x.pt;
    cmt_taken = x.tk; cmt_nlp_hit = x.hit; cmt_bim_state = x.bim;
  endtask

  task automatic idle();
    cmt_valid = 2'b00;
  endtask

  // Reference: pop the head, then each useful slot either refreshes the newest
  // remaining entry with the same PC, takes a free slot, or is counted as dropped.
  task automatic model_apply();
    logic   u [2];
    m_pkt_t p [2];
    for (int s = 0; s < 2; s++) begin
      logic h, t;
      h = cmt_nlp_hit[s];
      t = cmt_taken[s];
      u[s] = cmt_valid[s] && ((!h && t) || (h && t && cmt_bim_state[s] != 2'b11) ||
                              (h && !t && cmt_bim_state[s] != 2'b00) ||
                              (h && t && cmt_pred_target[s] != cmt_target[s]));
      p[s].pc = cmt_pc[s];
      p[s].target = cmt_target[s];
      p[s].bim = h ? cmt_bim_state[s] : 2'b10;
      p[s].take = t;
    end
    if (u[0] && u[1] && p[0].pc == p[1].pc) u[0] = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    for (int s = 0; s < 2; s++) begin
      if (u[s]) begin
        if (mq.size() != 0 && mq[mq.size()-1].pc == p[s].pc) mq[mq.size()-1] = p[s];
        else if (mq.size() < Depth) mq.push_back(p[s]);
        else if (mdrop != '1) mdrop++;
      end
    end
  endtask

  task automatic model_check();
    check("valid", 32'(upd_if.valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("pc", upd_if.pc, mq[0].pc);
      check("target", upd_if.target, mq[0].target);
      check("bim_state", 32'(upd_if.bim_state), 32'(mq[0].bim));
      check("should_take", 32'(upd_if.should_take), 32'(mq[0].take));
    end
    check("drop_cnt", 32'(drop_cnt), 32'(mdrop));
  endtask

  task automatic step();
    model_apply();
    @(posedge clk);
    #1;
    model_check();
  endtask

  initial begin
    int          pulses;
    logic [31:0] prev_pc;
    vec_t        busy;

    mdrop = '0;
    // Reset held with useful commits present.
    busy = mk(2'b11, 32'h700, 32'h780, 1, 0, 0, 0, 32'h704, 32'h784, 1, 0, 0, 0,
              0, 0, 0, 0, 0);
    drive(busy);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(upd_if.valid), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_pc", upd_if.pc, 0);
    check("rst_target", upd_if.target, 0);
    check("rst_bim", 32'(upd_if.bim_state), 0);
    check("rst_take", 32'(upd_if.should_take), 0);
    idle();
    rst_n = 1'b1;
    repeat (3) step();

    vecs[0] = mk(2'b11, 32'h1000, 32'h1400, 1, 0, 0, 0, 32'h2000, 32'h2400, 0, 0, 0, 0,
                 1, 32'h1000, 32'h1400, 2'b10, 1);
    vecs[1] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2] = mk(2'b01, 32'h4000, 32'h4800, 1, 1, 2'b11, 32'h4800, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0);
    vecs[3] = mk(2'b01, 32'h4000, 32'h4800, 1, 1, 2'b01, 32'h4800, 0, 0, 0, 0, 0, 0,
                 1, 32'h4000, 32'h4800, 2'b01, 1);
    vecs[4] = vecs[1];
    vecs[5] = mk(2'b11, 32'h3000, 32'h3100, 1, 0, 0, 0, 32'h3000, 32'h3004, 0, 1, 2'b10,
                 32'h3100, 1, 32'h3000, 32'h3004, 2'b10, 0);
    vecs[6] = vecs[1];
    vecs[7] = mk(2'b11, 32'h5000, 32'h5100, 1, 0, 0, 0, 32'h6000, 32'h6100, 1, 0, 0, 0,
                 1, 32'h5000, 32'h5100, 2'b10, 1);
    vecs[8] = mk(2'b01, 32'h6000, 32'h6004, 0, 1, 2'b11, 32'h6100, 0, 0, 0, 0, 0, 0,
                 1, 32'h6000, 32'h6004, 2'b11, 0);
    vecs[9] = vecs[1];
    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      check($sformatf("vec%0d_valid", i), 32'(upd_if.valid), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_pc", i), upd_if.pc, vecs[i].epc);
        check($sformatf("vec%0d_target", i), upd_if.target, vecs[i].etgt);
        check($sformatf("vec%0d_bim", i), 32'(upd_if.bim_state), 32'(vecs[i].eb));
        check($sformatf("vec%0d_take", i), 32'(upd_if.should_take), 32'(vecs[i].et));
      end
    end

    // Overflow: two distinct useful branches per cycle for 10 cycles.
    pulses = 0;
    prev_pc = '0;
    for (int k = 0; k < 10; k++) begin
      cmt_valid = 2'b11; cmt_taken = 2'b11; cmt_nlp_hit = 2'b00; cmt_bim_state = '0;
      for (int s = 0; s < 2; s++) begin
        cmt_pc[s] = 32'h10000 + 32'(8 * k + 4 * s);
        cmt_target[s] = 32'h20000 + 32'(8 * k + 4 * s);
        cmt_pred_target[s] = '0;
      end
      step();
      if (upd_if.valid) begin
        pulses++;
        check("ovf_order", 32'(upd_if.pc > prev_pc), 1);
        prev_pc = upd_if.pc;
      end
    end
    check("ovf_drops", 32'(drop_cnt), 3);
    idle();
    for (int k = 0; k < 30 && upd_if.valid; k++) begin
      step();
      if (upd_if.valid) begin
        pulses++;
        check("ovf_order", 32'(upd_if.pc > prev_pc), 1);
        prev_pc = upd_if.pc;
      end
    end
    check("ovf_pulses", 32'(pulses), 17);
    check("ovf_drained", 32'(upd_if.valid), 0);

    // Async reset with five entries queued.
    for (int k = 0; k < 4; k++) begin
      cmt_valid = 2'b11; cmt_taken = 2'b11; cmt_nlp_hit = 2'b00; cmt_bim_state = '0;
      cmt_pc[0] = 32'h9000 + 32'(8 * k);
      cmt_pc[1] = 32'h9004 + 32'(8 * k);
      step();
    end
    idle();
    check("pre_rst_count", 32'(mq.size()), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(upd_if.valid), 0);
    check("async_rst_drop", 32'(drop_cnt), 0);
    mq.delete();
    mdrop = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step();

    // Randomized traffic over a small PC pool to exercise both coalesce paths.
    for (int k = 0; k < 400; k++) begin
      cmt_valid = 2'($urandom_range(0, 3));
      for (int s = 0; s < 2; s++) begin
        cmt_pc[s] = 32'h100 + 32'(4 * $urandom_range(0, 5));
        cmt_target[s] = 32'h8000 + 32'(4 * $urandom_range(0, 1));
        cmt_pred_target[s] = 32'h8000 + 32'(4 * $urandom_range(0, 1));
        cmt_taken[s] = 1'($urandom_range(0, 1));
        cmt_nlp_hit[s] = 1'($urandom_range(0, 1));
        cmt_bim_state[s] = cmt_nlp_hit[s] ? 2'($urandom_range(0, 3)) : 2'b00;
      end
      step();
    end
    idle();
    repeat (Depth + 2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
